// File: rtl/pixel_plotter.sv
// Framebuffer-side pixel consumer: buffers signed pixel requests, bounds-checks them,
// issues linear-address writes, and provides a full-screen clear sweep.
module pixel_plotter #(
  parameter int WIDTH      = 640,
  parameter int HEIGHT     = 480,
  parameter int FIFO_DEPTH = 4,
  parameter int COLOR_W    = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic signed [10:0]        in_x,
  input  logic signed [10:0]        in_y,
  input  logic        [COLOR_W-1:0] in_color,
  input  logic                      clear_req,
  output logic                      clear_done,
  output logic                      busy,
  output logic        [18:0]        fb_addr,
  output logic        [COLOR_W-1:0] fb_wdata,
  output logic                      fb_we,
  output logic        [15:0]        drop_count
);

  localparam int AW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int ENT_W = 22 + COLOR_W;
  localparam logic [18:0] LAST_ADDR = 19'(WIDTH * HEIGHT - 1);

  typedef enum logic {RUN, CLEAR} state_t;

  state_t state, state_next;
  logic   clear_pending, pending_next;

  logic [ENT_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;
  logic             full, empty, push, pop, sweep_start;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign full     = (count == (AW+1)'(FIFO_DEPTH));
  assign empty    = (count == '0);
  assign in_ready = !reset && (state == RUN) && !full && !clear_pending;
  assign push     = in_valid && in_ready;
  assign pop      = (state == RUN) && !empty;
  // Sweep may only start once nothing is queued and the last pixel write has retired.
  assign sweep_start = (state == RUN) && clear_pending && empty && !fb_we;
  assign busy     = !empty || fb_we || clear_pending || (state == CLEAR);

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= RUN;
      clear_pending <= 1'b0;
    end else begin
      state         <= state_next;
      clear_pending <= pending_next;
    end
  end

  always_comb begin
    state_next   = state;
    pending_next = clear_pending;
    case (state)
      RUN: begin
        if (clear_pending) begin
          if (sweep_start) begin
            state_next   = CLEAR;
            pending_next = 1'b0;
          end
        end else if (clear_req) begin
          pending_next = 1'b1;
        end
      end
      CLEAR: begin
        if (clear_done) state_next = RUN;
      end
      default: state_next = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {in_x, in_y, in_color};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= AW'((32'(wr_ptr) + 1) % FIFO_DEPTH);
      if (pop)  rd_ptr <= AW'((32'(rd_ptr) + 1) % FIFO_DEPTH);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Stage p0: FIFO head decode, bounds check and address computation
  logic [ENT_W-1:0]   head_p0;
  logic signed [10:0] hx_p0, hy_p0;
  logic [COLOR_W-1:0] hc_p0;
  logic               inb_p0;
  logic [18:0]        addr_p0;

  always_comb begin
    head_p0 = mem[rd_ptr];
    hx_p0   = head_p0[ENT_W-1 -: 11];
    hy_p0   = head_p0[ENT_W-12 -: 11];
    hc_p0   = head_p0[COLOR_W-1:0];
    inb_p0  = (int'(hx_p0) >= 0) && (int'(hx_p0) <= WIDTH - 1) &&
              (int'(hy_p0) >= 0) && (int'(hy_p0) <= HEIGHT - 1);
    addr_p0 = 19'($unsigned(hy_p0)) * 19'(WIDTH) + 19'($unsigned(hx_p0));
  end

  // Stage p1: registered framebuffer write port
  always_ff @(posedge clk) begin
    if (reset) begin
      fb_we      <= 1'b0;
      fb_addr    <= '0;
      fb_wdata   <= '0;
      clear_done <= 1'b0;
      drop_count <= '0;
    end else begin
      fb_we      <= 1'b0;
      clear_done <= 1'b0;
      if (state == CLEAR) begin
        if (!clear_done) begin
          if (fb_addr == LAST_ADDR) begin
            clear_done <= 1'b1;
          end else begin
            fb_we    <= 1'b1;
            fb_addr  <= fb_addr + 19'd1;
            fb_wdata <= '0;
          end
        end
      end else if (sweep_start) begin
        fb_we    <= 1'b1;
        fb_addr  <= '0;
        fb_wdata <= '0;
      end else if (pop) begin
        if (inb_p0) begin
          fb_we    <= 1'b1;
          fb_addr  <= addr_p0;
          fb_wdata <= hc_p0;
        end else begin
          drop_count <= sat_inc(drop_count);
        end
      end
    end
  end

endmodule

// File: tb/tb_pixel_plotter.sv
// Directed bench for pixel_plotter: a default-size instance for pixel paths and
// drop saturation, and a 16x8 instance for clear-sweep sequences.
module tb_pixel_plotter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: default geometry
  logic               ra, va, cra;
  logic signed [10:0] xa, ya;
  logic [0:0]         ca, wda;
  logic               rdya, cda, busya, wea;
  logic [18:0]        addra;
  logic [15:0]        dropa;

  pixel_plotter dut_a (
    .clk(clk), .reset(ra), .in_valid(va), .in_ready(rdya), .in_x(xa), .in_y(ya),
    .in_color(ca), .clear_req(cra), .clear_done(cda), .busy(busya),
    .fb_addr(addra), .fb_wdata(wda), .fb_we(wea), .drop_count(dropa)
  );

  // Instance B: small screen so a full sweep is short
  logic               rb, vb, crb;
  logic signed [10:0] xb, yb;
  logic [1:0]         cb, wdb;
  logic               rdyb, cdb, busyb, web;
  logic [18:0]        addrb;
  logic [15:0]        dropb;

  pixel_plotter #(.WIDTH(16), .HEIGHT(8), .FIFO_DEPTH(4), .COLOR_W(2)) dut_b (
    .clk(clk), .reset(rb), .in_valid(vb), .in_ready(rdyb), .in_x(xb), .in_y(yb),
    .in_color(cb), .clear_req(crb), .clear_done(cdb), .busy(busyb),
    .fb_addr(addrb), .fb_wdata(wdb), .fb_we(web), .drop_count(dropb)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic signed [10:0] x;
    logic signed [10:0] y;
    logic [0:0]         c;
    logic               we;
    logic [18:0]        addr;
    logic [0:0]         d;
  } vec_t;

  typedef struct packed {
    logic        we;
    logic [18:0] addr;
    logic [1:0]  data;
    logic        done;
    logic        rdy;
  } rec_t;

  vec_t vecs [11];
  rec_t log_q [$];
  rec_t wr_q  [$];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int exp_drop;
    int sweep_bad, rdy_bad, done_cnt, first_sweep, done_idx;

    vecs[0]  = '{x:5,     y:3,     c:1, we:1, addr:1925,   d:1};
    vecs[1]  = '{x:-1,    y:5,     c:1, we:0, addr:0,      d:0};
    vecs[2]  = '{x:640,   y:0,     c:1, we:0, addr:0,      d:0};
    vecs[3]  = '{x:0,     y:480,   c:1, we:0, addr:0,      d:0};
    vecs[4]  = '{x:639,   y:479,   c:1, we:1, addr:307199, d:1};
    vecs[5]  = '{x:0,     y:0,     c:1, we:1, addr:0,      d:1};
    vecs[6]  = '{x:0,     y:479,   c:0, we:1, addr:306560, d:0};
    vecs[7]  = '{x:-1024, y:-1024, c:1, we:0, addr:0,      d:0};
    vecs[8]  = '{x:1023,  y:0,     c:1, we:0, addr:0,      d:0};
    vecs[9]  = '{x:639,   y:0,     c:0, we:1, addr:639,    d:0};
    vecs[10] = '{x:0,     y:-1,    c:1, we:0, addr:0,      d:0};

    ra = 1'b1; va = 1'b0; cra = 1'b0; xa = '0; ya = '0; ca = '0;
    rb = 1'b1; vb = 1'b0; crb = 1'b0; xb = '0; yb = '0; cb = '0;
    #1;
    check("rdy_in_reset_a", rdya, 0);
    step(); step();
    check("rdy_in_reset_b", rdyb, 0);
    ra = 1'b0; rb = 1'b0;
    #1;
    check("rst_rdy", rdya, 1);
    check("rst_we", wea, 0);
    check("rst_addr", addra, 0);
    check("rst_wdata", wda, 0);
    check("rst_done", cda, 0);
    check("rst_busy", busya, 0);
    check("rst_drop", dropa, 0);

    // Single-pixel vectors on instance A
    exp_drop = 0;
    for (int i = 0; i < 11; i++) begin
      xa = vecs[i].x; ya = vecs[i].y; ca = vecs[i].c; va = 1'b1;
      step();
      va = 1'b0;
      step();
      check($sformatf("vec%0d_we", i), wea, vecs[i].we);
      if (vecs[i].we) begin
        check($sformatf("vec%0d_addr", i), addra, vecs[i].addr);
        check($sformatf("vec%0d_data", i), wda, vecs[i].d);
        check($sformatf("vec%0d_busy", i), busya, 1);
      end else begin
        exp_drop++;
      end
      check($sformatf("vec%0d_drop", i), dropa, exp_drop);
      step();
      check($sformatf("vec%0d_idle", i), busya, 0);
    end

    // Back-to-back diagonal stream
    for (int c = 0; c < 10; c++) begin
      if (c < 8) begin
        va = 1'b1; xa = 11'(c); ya = 11'(c); ca = 1'b1;
        check($sformatf("diag_rdy%0d", c), rdya, 1);
      end else begin
        va = 1'b0;
      end
      step();
      if (c >= 1 && c <= 8) begin
        check($sformatf("diag_we%0d", c - 1), wea, 1);
        check($sformatf("diag_addr%0d", c - 1), addra, (c - 1) * 641);
      end
    end
    check("diag_tail_we", wea, 0);

    // Clear with an empty FIFO on B, preceded by one dropped pixel
    xb = 16; yb = 0; cb = 2'd1; vb = 1'b1;
    step();
    vb = 1'b0;
    step();
    check("b_drop", dropb, 1);
    crb = 1'b1;
    step();
    crb = 1'b0;
    check("clr_pending_busy", busyb, 1);
    check("clr_pending_rdy", rdyb, 0);
    check("clr_pending_we", web, 0);
    step();
    check("clr_first_we", web, 1);
    check("clr_first_addr", addrb, 0);
    check("clr_first_data", wdb, 0);
    for (int k = 0; k < 400 && !cdb; k++) step();
    check("clr_done_seen", cdb, 1);
    check("clr_done_rdy", rdyb, 0);
    check("clr_done_we", web, 0);
    step();
    check("clr_after_rdy", rdyb, 1);
    check("clr_after_done", cdb, 0);

    // Three pixels in flight, clear requested with the last push
    log_q.delete();
    vb = 1'b1; xb = 1;  yb = 1; cb = 2'd3;
    step(); log_q.push_back('{we:web, addr:addrb, data:wdb, done:cdb, rdy:rdyb});
    xb = 15; yb = 7; cb = 2'd2;
    step(); log_q.push_back('{we:web, addr:addrb, data:wdb, done:cdb, rdy:rdyb});
    xb = 2;  yb = 0; cb = 2'd1; crb = 1'b1;
    step(); log_q.push_back('{we:web, addr:addrb, data:wdb, done:cdb, rdy:rdyb});
    vb = 1'b0; crb = 1'b0;
    for (int k = 0; k < 400; k++) begin
      step();
      log_q.push_back('{we:web, addr:addrb, data:wdb, done:cdb, rdy:rdyb});
      if (log_q[log_q.size()-2].done) break;
    end
    wr_q.delete();
    done_cnt = 0; done_idx = -1; first_sweep = -1;
    foreach (log_q[i]) begin
      if (log_q[i].we) begin
        wr_q.push_back(log_q[i]);
        if (wr_q.size() == 4) first_sweep = i;
      end
      if (log_q[i].done) begin
        done_cnt++;
        done_idx = i;
      end
    end
    check("hold_writes", wr_q.size(), 3 + 128);
    check("hold_done_cnt", done_cnt, 1);
    if (wr_q.size() >= 3) begin
      check("hold_p0_addr", wr_q[0].addr, 17);
      check("hold_p0_data", wr_q[0].data, 3);
      check("hold_p1_addr", wr_q[1].addr, 127);
      check("hold_p1_data", wr_q[1].data, 2);
      check("hold_p2_addr", wr_q[2].addr, 2);
      check("hold_p2_data", wr_q[2].data, 1);
    end
    sweep_bad = 0;
    for (int j = 3; j < wr_q.size(); j++)
      if (wr_q[j].addr != 19'(j - 3) || wr_q[j].data != 2'd0) sweep_bad++;
    check("hold_sweep_seq", sweep_bad, 0);
    rdy_bad = 0;
    if (first_sweep >= 0 && done_idx >= first_sweep) begin
      for (int i = first_sweep; i <= done_idx; i++)
        if (log_q[i].rdy) rdy_bad++;
    end else begin
      rdy_bad = 1;
    end
    check("hold_sweep_rdy_low", rdy_bad, 0);
    if (done_idx >= 0 && done_idx + 1 < log_q.size())
      check("hold_rdy_after_done", log_q[done_idx+1].rdy, 1);
    else
      check("hold_rdy_after_done", 0, 1);

    // Reset in the middle of a sweep
    crb = 1'b1;
    step();
    crb = 1'b0;
    for (int k = 0; k < 100; k++) step();
    check("mid_sweep_we", web, 1);
    rb = 1'b1;
    #1;
    check("mid_rst_rdy", rdyb, 0);
    step();
    rb = 1'b0;
    #1;
    check("post_rst_we", web, 0);
    check("post_rst_busy", busyb, 0);
    check("post_rst_rdy", rdyb, 1);
    check("post_rst_done", cdb, 0);
    check("post_rst_drop", dropb, 0);
    vb = 1'b1; xb = 1; yb = 0; cb = 2'd1;
    step();
    vb = 1'b0;
    check("post_rst_done2", cdb, 0);
    step();
    check("post_rst_px_we", web, 1);
    check("post_rst_px_addr", addrb, 1);
    check("post_rst_px_data", wdb, 1);
    step();
    check("post_rst_done3", cdb, 0);
    check("post_rst_idle", busyb, 0);

    // Drop counter saturation on A
    ra = 1'b1;
    step();
    ra = 1'b0;
    #1;
    check("sat_start", dropa, 0);
    va = 1'b1; xa = -5; ya = -5; ca = 1'b1;
    for (int k = 0; k < 65535; k++) step();
    va = 1'b0;
    step(); step();
    check("sat_reach", dropa, 65535);
    va = 1'b1; xa = 700; ya = 10;
    step();
    va = 1'b0;
    step(); step();
    check("sat_hold", dropa, 65535);
    check("sat_no_write", wea, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
